// File: rtl/radix_multi_if.sv
// Handshake bundle for radix_multi.
//   master : upstream/downstream side (drives operands, in_vld, out_rdy)
//   slave  : the multiplier (drives in_rdy, out_vld, product, busy)
// Signals:
//   in_vld/in_rdy    operand handshake, transfer when both high on a rising edge
//   dat1, dat2       multiplicand, multiplier (DATA_WIDTH bits)
//   is_signed        operands are two's complement, sampled with in_vld
//   out_vld/out_rdy  result handshake, transfer when both high on a rising edge
//   product          2*DATA_WIDTH-bit result
//   busy             multiplier is not idle
interface radix_multi_if #(
  parameter int DATA_WIDTH = 2048
);
  logic                    in_vld;
  logic                    in_rdy;
  logic [DATA_WIDTH-1:0]   dat1;
  logic [DATA_WIDTH-1:0]   dat2;
  logic                    is_signed;
  logic                    out_vld;
  logic                    out_rdy;
  logic [2*DATA_WIDTH-1:0] product;
  logic                    busy;

  modport master (
    output in_vld, dat1, dat2, is_signed, out_rdy,
    input  in_rdy, out_vld, product, busy
  );

  modport slave (
    input  in_vld, dat1, dat2, is_signed, out_rdy,
    output in_rdy, out_vld, product, busy
  );
endinterface

// File: rtl/radix_multi.sv
// Multi-cycle shift-add multiplier retiring RADIX_BITS multiplier bits per
// cycle. Signed operation multiplies magnitudes and negates the result.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        radix_multi_if slave (operand and result handshakes)
//   dbg_state  current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. in_rdy is high only in IDLE; out_vld is high only in
// DONE and, once high, stays high with product stable until out_rdy is seen.
// Valid never depends combinationally on the matching ready.
module radix_multi #(
  parameter int DATA_WIDTH = 2048,
  parameter int RADIX_BITS = 1,
  parameter int SIGNED_EN  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  radix_multi_if.slave    bus,
  output logic [1:0]      dbg_state
);

  localparam int W     = DATA_WIDTH;
  localparam int R     = RADIX_BITS;
  localparam int NSTEP = W / R;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  if ((RADIX_BITS < 1) || ((DATA_WIDTH % RADIX_BITS) != 0)) begin : g_bad_cfg
    $error("radix_multi: RADIX_BITS (%0d) must divide DATA_WIDTH (%0d)",
           RADIX_BITS, DATA_WIDTH);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] prod_q;
  logic [2*W-1:0] term;
  logic [2*W-1:0] sum;
  logic [CW-1:0]  cnt;
  logic           neg;

  logic           accept;
  logic           signed_op;
  logic [W-1:0]   mag1;
  logic [W-1:0]   mag2;

  assign accept    = (state == IDLE) && bus.in_vld;
  assign signed_op = bus.is_signed && (SIGNED_EN != 0);

  // Two's-complement magnitude in W bits: the most negative value maps to
  // 2^(W-1), which is still representable as an unsigned W-bit number.
  assign mag1 = (signed_op && bus.dat1[W-1]) ? (~bus.dat1 + 1'b1) : bus.dat1;
  assign mag2 = (signed_op && bus.dat2[W-1]) ? (~bus.dat2 + 1'b1) : bus.dat2;

  // Partial product for the current digit, aligned to its weight.
  always_comb begin
    term = ({{W{1'b0}}, mcand} * {{(2*W-R){1'b0}}, mplier[R-1:0]}) << (cnt * R);
    sum  = acc + term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bus.in_rdy  = 1'b0;
    bus.out_vld = 1'b0;
    bus.busy    = 1'b1;
    case (state)
      IDLE: begin
        bus.in_rdy = 1'b1;
        bus.busy   = 1'b0;
        if (bus.in_vld) state_nxt = CALC;
      end
      CALC: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        bus.out_vld = 1'b1;
        if (bus.out_rdy) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      prod_q <= '0;
    end else if (accept) begin
      mcand  <= mag1;
      mplier <= mag2;
      neg    <= signed_op && (bus.dat1[W-1] ^ bus.dat2[W-1]);
      acc    <= '0;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc    <= sum;
      mplier <= mplier >> R;
      cnt    <= cnt + 1'b1;
      // Negating a zero sum yields zero, so no -0 can appear.
      if (cnt == LAST) prod_q <= neg ? (~sum + 1'b1) : sum;
    end
  end

  assign bus.product = prod_q;
  assign dbg_state   = state;

endmodule
